// File: rtl/seg_display_arbiter.sv
// Round-robin arbiter sharing the 8-digit seven-segment display between the
// CPU MMIO store path and the debug/status source, with a minimum dwell per owner.
module seg_display_arbiter #(
  parameter int DWELL = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        cpu_req,
  input  logic [31:0] cpu_value,
  output logic        cpu_ack,
  input  logic        dbg_req,
  input  logic [31:0] dbg_value,
  output logic        dbg_ack,
  output logic [31:0] disp_value,
  output logic        disp_en,
  output logic [1:0]  owner
);

  localparam int DATA_W = 32;
  localparam int CNT_W  = $clog2(DWELL + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DWELL - 1);

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_DBG  = 2'b10;

  typedef enum logic [1:0] {IDLE, SHOW_CPU, SHOW_DBG} state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_rr_dbg;
  logic                r_cpu_ack;
  logic                r_dbg_ack;
  logic [DATA_W-1:0]   r_disp_value;
  logic                r_disp_en;
  logic [1:0]          r_owner;

  state_t              w_state_nxt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_rr_dbg_nxt;
  logic                w_cpu_ack_nxt;
  logic                w_dbg_ack_nxt;
  logic [DATA_W-1:0]   w_disp_value_nxt;
  logic                w_disp_en_nxt;
  logic [1:0]          w_owner_nxt;

  logic                w_cpu_req;
  logic                w_dbg_req;
  logic                w_cnt_zero;
  logic [CNT_W-1:0]    w_cnt_dec;
  logic                w_grant_cpu;
  logic                w_grant_dbg;

  // A requester's level is ignored during the cycle its own ack is showing.
  assign w_cpu_req  = cpu_req & ~r_cpu_ack;
  assign w_dbg_req  = dbg_req & ~r_dbg_ack;
  assign w_cnt_zero = (r_cnt == '0);
  assign w_cnt_dec  = w_cnt_zero ? '0 : r_cnt - CNT_W'(1);

  always_comb begin
    w_grant_cpu = 1'b0;
    w_grant_dbg = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cpu_req && w_dbg_req) begin
          w_grant_dbg = r_rr_dbg;
          w_grant_cpu = ~r_rr_dbg;
        end else begin
          w_grant_cpu = w_cpu_req;
          w_grant_dbg = w_dbg_req;
        end
      end
      SHOW_CPU: begin
        if (w_dbg_req && w_cnt_zero) w_grant_dbg = 1'b1;
        else if (w_cpu_req)          w_grant_cpu = 1'b1;
      end
      SHOW_DBG: begin
        if (w_cpu_req && w_cnt_zero) w_grant_cpu = 1'b1;
        else if (w_dbg_req)          w_grant_dbg = 1'b1;
      end
      default: begin
        w_grant_cpu = 1'b0;
        w_grant_dbg = 1'b0;
      end
    endcase
    if (clr) begin
      w_grant_cpu = 1'b0;
      w_grant_dbg = 1'b0;
    end
  end

  always_comb begin
    w_state_nxt      = (r_state == SHOW_CPU || r_state == SHOW_DBG) ? r_state : IDLE;
    w_cnt_nxt        = w_cnt_dec;
    w_rr_dbg_nxt     = r_rr_dbg;
    w_cpu_ack_nxt    = 1'b0;
    w_dbg_ack_nxt    = 1'b0;
    w_disp_value_nxt = r_disp_value;
    w_disp_en_nxt    = (w_state_nxt == IDLE) ? 1'b0 : r_disp_en;
    w_owner_nxt      = (w_state_nxt == IDLE) ? OWN_NONE : r_owner;
    if (clr) begin
      // Value is retained while blanked; only enable and ownership drop.
      w_state_nxt   = IDLE;
      w_cnt_nxt     = '0;
      w_disp_en_nxt = 1'b0;
      w_owner_nxt   = OWN_NONE;
    end else if (w_grant_cpu) begin
      w_state_nxt      = SHOW_CPU;
      w_cnt_nxt        = CNT_LOAD;
      w_rr_dbg_nxt     = 1'b1;
      w_cpu_ack_nxt    = 1'b1;
      w_disp_value_nxt = cpu_value;
      w_disp_en_nxt    = 1'b1;
      w_owner_nxt      = OWN_CPU;
    end else if (w_grant_dbg) begin
      w_state_nxt      = SHOW_DBG;
      w_cnt_nxt        = CNT_LOAD;
      w_rr_dbg_nxt     = 1'b0;
      w_dbg_ack_nxt    = 1'b1;
      w_disp_value_nxt = dbg_value;
      w_disp_en_nxt    = 1'b1;
      w_owner_nxt      = OWN_DBG;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_rr_dbg     <= 1'b0;
      r_cpu_ack    <= 1'b0;
      r_dbg_ack    <= 1'b0;
      r_disp_value <= '0;
      r_disp_en    <= 1'b0;
      r_owner      <= OWN_NONE;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_rr_dbg     <= w_rr_dbg_nxt;
      r_cpu_ack    <= w_cpu_ack_nxt;
      r_dbg_ack    <= w_dbg_ack_nxt;
      r_disp_value <= w_disp_value_nxt;
      r_disp_en    <= w_disp_en_nxt;
      r_owner      <= w_owner_nxt;
    end
  end

  assign cpu_ack    = r_cpu_ack;
  assign dbg_ack    = r_dbg_ack;
  assign disp_value = r_disp_value;
  assign disp_en    = r_disp_en;
  assign owner      = r_owner;

endmodule
